// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: instruction codes, TAP state encodings and the
// data-register selection decode used by the DR unit.
package jtag_pkg;

  localparam int IR_WIDTH = 4;

  // Instruction register codes
  typedef enum logic [3:0] {
    IR_EXTEST       = 4'b0000,
    IR_IDCODE       = 4'b0001,
    IR_SAMPLE       = 4'b0010,
    IR_IJTAG_ACCESS = 4'b0011,
    IR_BYPASS       = 4'b1111
  } ir_code_t;

  // TAP controller state encodings (IEEE 1149.1 customary values)
  typedef enum logic [3:0] {
    TAP_EXIT2_DR         = 4'h0,
    TAP_EXIT1_DR         = 4'h1,
    TAP_SHIFT_DR         = 4'h2,
    TAP_PAUSE_DR         = 4'h3,
    TAP_SELECT_IR        = 4'h4,
    TAP_UPDATE_DR        = 4'h5,
    TAP_CAPTURE_DR       = 4'h6,
    TAP_SELECT_DR        = 4'h7,
    TAP_EXIT2_IR         = 4'h8,
    TAP_EXIT1_IR         = 4'h9,
    TAP_SHIFT_IR         = 4'hA,
    TAP_PAUSE_IR         = 4'hB,
    TAP_RUN_TEST_IDLE    = 4'hC,
    TAP_UPDATE_IR        = 4'hD,
    TAP_CAPTURE_IR       = 4'hE,
    TAP_TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

  // Which data register sits between tdi and tdo
  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_IJTAG  = 2'd2
  } dr_sel_t;

  // Every code without a dedicated DR here (EXTEST/SAMPLE use an external BSR) maps to BYPASS
  function automatic dr_sel_t decode_dr(input logic [IR_WIDTH-1:0] ir);
    dr_sel_t sel;
    case (ir)
      IR_IDCODE:       sel = DR_IDCODE;
      IR_IJTAG_ACCESS: sel = DR_IJTAG;
      default:         sel = DR_BYPASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/jtag_sib.sv
// IEEE 1687 Segment Insertion Bit: shift bit, update bit and the path mux that
// splices the client segment in front of the SIB when the update bit is set.
module jtag_sib (
  input  logic tck,
  input  logic trst_n,
  input  logic tlr,          // Test-Logic-Reset, synchronous clear
  input  logic sel,          // this SIB's network is the selected DR
  input  logic capture,
  input  logic shift,
  input  logic update,
  input  logic si,           // scan in from the host side
  input  logic from_client,  // scan out of the client segment
  output logic to_client,    // scan in of the client segment
  output logic so,           // scan out toward the host
  output logic update_bit    // 1 = client segment inserted
);

  logic shift_bit;

  // Shift bit: captures the update bit, then shifts from the client (open) or directly from si (closed)
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      shift_bit <= 1'b0;
    end else if (tlr) begin
      // cleared with the update bit so the scan output reads 0 in Test-Logic-Reset
      shift_bit <= 1'b0;
    end else if (sel) begin
      if (capture) begin
        shift_bit <= update_bit;
      end else if (shift) begin
        shift_bit <= update_bit ? from_client : si;
      end
    end
  end

  // Update bit: loaded from the shift bit on update; capture/shift take precedence
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      update_bit <= 1'b0;
    end else if (tlr) begin
      update_bit <= 1'b0;
    end else if (sel && !capture && !shift && update) begin
      update_bit <= shift_bit;
    end
  end

  assign to_client = si;
  assign so        = shift_bit;

endmodule

// File: rtl/jtag_dr_unit.sv
// JTAG data-register unit: IDCODE, BYPASS and an IJTAG network consisting of a
// SIB guarding one instrument TDR with its update register.
module jtag_dr_unit
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE_VALUE = 32'h1A2B_3C4D,  // bit 0 must be 1
  parameter int          TDR_WIDTH    = 8
) (
  input  logic                 tck,
  input  logic                 trst_n,
  input  logic [3:0]           ir_reg,
  input  logic                 test_logic_reset_state,
  input  logic                 capture_dr_state,
  input  logic                 shift_dr_state,
  input  logic                 update_dr_state,
  input  logic                 tdi,
  output logic                 tdo_dr,
  input  logic [TDR_WIDTH-1:0] instr_in,
  output logic [TDR_WIDTH-1:0] instr_out,
  output logic                 sib_open
);

  dr_sel_t              dr_sel;
  logic                 do_capture;
  logic                 do_shift;
  logic                 do_update;
  logic                 sel_ijtag;
  logic [31:0]          idcode_shreg;
  logic                 bypass_bit;
  logic [TDR_WIDTH-1:0] tdr_shreg;
  logic [TDR_WIDTH:0]   tdr_ext;
  logic                 tdr_si;
  logic                 sib_so;

  assign dr_sel     = decode_dr(ir_reg);
  assign sel_ijtag  = (dr_sel == DR_IJTAG);
  // Indicator priority: capture > shift > update
  assign do_capture = capture_dr_state;
  assign do_shift   = shift_dr_state && !capture_dr_state;
  assign do_update  = update_dr_state && !capture_dr_state && !shift_dr_state;
  // TDR with its scan input prepended; bit 0 is the TDR scan output into the SIB
  assign tdr_ext    = {tdr_si, tdr_shreg};

  // IDCODE register: loads the device ID, shifts LSB first toward tdo
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      idcode_shreg <= '0;
    end else if (!test_logic_reset_state && dr_sel == DR_IDCODE) begin
      if (do_capture) begin
        idcode_shreg <= IDCODE_VALUE;
      end else if (do_shift) begin
        idcode_shreg <= {tdi, idcode_shreg[31:1]};
      end
    end
  end

  // Bypass bit: captures 0, single-stage delay while shifting
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      bypass_bit <= 1'b0;
    end else if (!test_logic_reset_state && dr_sel == DR_BYPASS) begin
      if (do_capture) begin
        bypass_bit <= 1'b0;
      end else if (do_shift) begin
        bypass_bit <= tdi;
      end
    end
  end

  // Instrument TDR shift register: active only while the SIB has it in the path
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdr_shreg <= '0;
    end else if (!test_logic_reset_state && sel_ijtag && sib_open) begin
      if (do_capture) begin
        tdr_shreg <= instr_in;
      end else if (do_shift) begin
        tdr_shreg <= tdr_ext[TDR_WIDTH:1];
      end
    end
  end

  // Instrument update register: written only if the TDR was in the path during this scan
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      instr_out <= '0;
    end else if (test_logic_reset_state) begin
      instr_out <= '0;
    end else if (sel_ijtag && do_update && sib_open) begin
      instr_out <= tdr_shreg;
    end
  end

  jtag_sib u_sib (
    .tck         (tck),
    .trst_n      (trst_n),
    .tlr         (test_logic_reset_state),
    .sel         (sel_ijtag),
    .capture     (do_capture),
    .shift       (do_shift),
    .update      (do_update),
    .si          (tdi),
    .from_client (tdr_ext[0]),
    .to_client   (tdr_si),
    .so          (sib_so),
    .update_bit  (sib_open)
  );

  // Scan output mux: output-end bit of the selected chain, unregistered
  always_comb begin
    tdo_dr = bypass_bit;
    case (dr_sel)
      DR_IDCODE: tdo_dr = idcode_shreg[0];
      DR_IJTAG:  tdo_dr = sib_so;
      default:   tdo_dr = bypass_bit;
    endcase
  end

endmodule

// File: tb/tb_jtag_dr_unit.sv
// Self-checking bench for jtag_dr_unit: expected tdo_dr bits go into a
// scoreboard queue as each scan is set up and are popped against observed bits.
module tb_jtag_dr_unit;

  localparam logic [31:0] IDV = 32'h1A2B_3C4D;
  localparam int          W   = 8;

  logic         tck = 1'b0;
  logic         trst_n;
  logic [3:0]   ir_reg;
  logic         test_logic_reset_state;
  logic         capture_dr_state;
  logic         shift_dr_state;
  logic         update_dr_state;
  logic         tdi;
  logic         tdo_dr;
  logic [W-1:0] instr_in;
  logic [W-1:0] instr_out;
  logic         sib_open;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_q[$];
  logic obs_q[$];

  always #5 tck = ~tck;

  jtag_dr_unit #(.IDCODE_VALUE(IDV), .TDR_WIDTH(W)) dut (
    .tck                    (tck),
    .trst_n                 (trst_n),
    .ir_reg                 (ir_reg),
    .test_logic_reset_state (test_logic_reset_state),
    .capture_dr_state       (capture_dr_state),
    .shift_dr_state         (shift_dr_state),
    .update_dr_state        (update_dr_state),
    .tdi                    (tdi),
    .tdo_dr                 (tdo_dr),
    .instr_in               (instr_in),
    .instr_out              (instr_out),
    .sib_open               (sib_open)
  );

  // One TAP cycle with the given indicators and tdi; returns 1 time unit after the edge
  task automatic step(input logic c, input logic s, input logic u, input logic t);
    @(negedge tck);
    capture_dr_state = c;
    shift_dr_state   = s;
    update_dr_state  = u;
    tdi              = t;
    @(posedge tck);
    #1;
  endtask

  // Shift n bits of stream (bit 0 first), recording tdo_dr before each edge
  task automatic shift_scan(input int n, input logic [15:0] stream);
    for (int i = 0; i < n; i++) begin
      @(negedge tck);
      capture_dr_state = 1'b0;
      shift_dr_state   = 1'b1;
      update_dr_state  = 1'b0;
      tdi              = stream[i];
      #1;
      obs_q.push_back(tdo_dr);
      @(posedge tck);
      #1;
    end
  endtask

  task automatic push_byte_lsb(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
  endtask

  task automatic test_reset();
    trst_n = 1'b1;
    #1;
    trst_n = 1'b0;
    #2;
    n_checks++; if (tdo_dr !== 1'b0) begin n_fail++; $display("FAIL reset_tdo: got %b want 0", tdo_dr); end
    n_checks++; if (sib_open !== 1'b0) begin n_fail++; $display("FAIL reset_sib: got %b want 0", sib_open); end
    n_checks++; if (instr_out !== 8'h00) begin n_fail++; $display("FAIL reset_instr_out: got %h want 00", instr_out); end
    @(negedge tck);
    trst_n = 1'b1;
    $display("reset: outputs checked");
  endtask

  task automatic test_idcode();
    ir_reg = 4'b0001;
    step(1, 0, 0, 0);
    for (int i = 0; i < 32; i++) exp_q.push_back(IDV[i]);
    shift_scan(32, 16'h0000);
    n_checks++; if (tdo_dr !== 1'b0) begin n_fail++; $display("FAIL idcode_after32: got %b want 0", tdo_dr); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL idcode_bit%0d: got %b want %b", i, o, e); end
    end
    step(0, 0, 0, 0);
    $display("idcode: 32-bit scan done");
  endtask

  task automatic test_bypass();
    ir_reg = 4'b1111;
    step(1, 0, 0, 0);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    shift_scan(4, 16'b0011);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL bypass_bit%0d: got %b want %b", i, o, e); end
    end
    step(0, 0, 0, 0);
    $display("bypass: 4-bit scan done");
  endtask

  task automatic test_sib_closed();
    ir_reg   = 4'b0011;
    instr_in = 8'h77;
    step(1, 0, 0, 0);
    exp_q.push_back(1'b0);
    shift_scan(1, 16'h0001);
    n_checks++; if (tdo_dr !== 1'b1) begin n_fail++; $display("FAIL closed_len1: tdo got %b want 1", tdo_dr); end
    while (exp_q.size() > 0) begin
      logic e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL closed_sib_capture: got %b want %b", o, e); end
    end
    step(0, 0, 1, 0);
    n_checks++; if (sib_open !== 1'b1) begin n_fail++; $display("FAIL closed_update_sib: got %b want 1", sib_open); end
    n_checks++; if (instr_out !== 8'h00) begin n_fail++; $display("FAIL closed_update_instr: got %h want 00", instr_out); end
    step(0, 0, 0, 0);
    $display("ijtag closed: sib opened");
  endtask

  // Full open-SIB scan: captured SIB/TDR come out, wr_data + sib bit go in
  task automatic open_scan(input logic [7:0] cap_val, input logic [7:0] wr_val, input logic sib_in,
                           input logic [7:0] want_out, input logic want_sib, input string tag);
    logic [15:0] stream;
    stream   = {7'd0, wr_val, sib_in};
    instr_in = cap_val;
    step(1, 0, 0, 0);
    exp_q.push_back(1'b1);
    push_byte_lsb(cap_val);
    shift_scan(9, stream);
    n_checks++; if (instr_out === want_out && want_out !== wr_val) begin n_fail++; $display("FAIL %s_preupdate: instr_out %h changed during shift", tag, instr_out); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL %s_bit%0d: got %b want %b", tag, i, o, e); end
    end
    step(0, 0, 1, 0);
    n_checks++; if (instr_out !== want_out) begin n_fail++; $display("FAIL %s_instr_out: got %h want %h", tag, instr_out, want_out); end
    n_checks++; if (sib_open !== want_sib) begin n_fail++; $display("FAIL %s_sib: got %b want %b", tag, sib_open, want_sib); end
    step(0, 0, 0, 0);
    $display("%s: scan of %h done", tag, wr_val);
  endtask

  task automatic test_sib_open();
    ir_reg = 4'b0011;
    open_scan(8'h77, 8'hA5, 1'b1, 8'hA5, 1'b1, "open");
  endtask

  task automatic test_next_scan();
    ir_reg = 4'b0011;
    open_scan(8'h3C, 8'hA5, 1'b1, 8'hA5, 1'b1, "next");
  endtask

  task automatic test_other_dr_update();
    ir_reg = 4'b0001;
    step(1, 0, 0, 0);
    exp_q.push_back(IDV[0]); exp_q.push_back(IDV[1]); exp_q.push_back(IDV[2]);
    shift_scan(3, 16'h0007);
    step(0, 0, 1, 0);
    ir_reg = 4'b1111;
    step(1, 0, 0, 0);
    exp_q.push_back(1'b0);
    shift_scan(1, 16'h0000);
    step(0, 0, 1, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL other_bit%0d: got %b want %b", i, o, e); end
    end
    n_checks++; if (sib_open !== 1'b1) begin n_fail++; $display("FAIL other_update_sib: got %b want 1", sib_open); end
    n_checks++; if (instr_out !== 8'hA5) begin n_fail++; $display("FAIL other_update_instr: got %h want a5", instr_out); end
    step(0, 0, 0, 0);
    $display("idcode/bypass updates: no output change");
  endtask

  task automatic test_sib_close();
    ir_reg = 4'b0011;
    open_scan(8'h11, 8'h5A, 1'b0, 8'h5A, 1'b0, "close");
    step(1, 0, 0, 0);
    exp_q.push_back(1'b0);
    shift_scan(1, 16'h0001);
    n_checks++; if (tdo_dr !== 1'b1) begin n_fail++; $display("FAIL reclosed_len1: tdo got %b want 1", tdo_dr); end
    while (exp_q.size() > 0) begin
      logic e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL reclosed_capture: got %b want %b", o, e); end
    end
    step(0, 0, 1, 0);
    n_checks++; if (sib_open !== 1'b1) begin n_fail++; $display("FAIL reopen_sib: got %b want 1", sib_open); end
    n_checks++; if (instr_out !== 8'h5A) begin n_fail++; $display("FAIL reopen_instr_hold: got %h want 5a", instr_out); end
    step(0, 0, 0, 0);
    $display("sib close/reopen done");
  endtask

  task automatic test_trst_abort();
    ir_reg   = 4'b0011;
    instr_in = 8'hFF;
    step(1, 0, 0, 0);
    shift_scan(4, 16'h000F);
    obs_q.delete();
    @(negedge tck);
    #2;
    trst_n = 1'b0;
    #1;
    n_checks++; if (tdo_dr !== 1'b0) begin n_fail++; $display("FAIL trst_tdo: got %b want 0", tdo_dr); end
    n_checks++; if (sib_open !== 1'b0) begin n_fail++; $display("FAIL trst_sib: got %b want 0", sib_open); end
    n_checks++; if (instr_out !== 8'h00) begin n_fail++; $display("FAIL trst_instr: got %h want 00", instr_out); end
    @(negedge tck);
    trst_n         = 1'b1;
    shift_dr_state = 1'b0;
    step(0, 0, 1, 0);
    n_checks++; if (sib_open !== 1'b0) begin n_fail++; $display("FAIL trst_noupdate_sib: got %b want 0", sib_open); end
    n_checks++; if (instr_out !== 8'h00) begin n_fail++; $display("FAIL trst_noupdate_instr: got %h want 00", instr_out); end
    step(1, 0, 0, 0);
    exp_q.push_back(1'b0);
    shift_scan(1, 16'h0001);
    step(0, 0, 1, 0);
    while (exp_q.size() > 0) begin
      logic e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL resume_capture: got %b want %b", o, e); end
    end
    n_checks++; if (sib_open !== 1'b1) begin n_fail++; $display("FAIL resume_sib: got %b want 1", sib_open); end
    step(0, 0, 0, 0);
    open_scan(8'h99, 8'hC3, 1'b1, 8'hC3, 1'b1, "resume");
  endtask

  task automatic test_tlr();
    @(negedge tck);
    test_logic_reset_state = 1'b1;
    update_dr_state        = 1'b1;
    @(posedge tck);
    #1;
    n_checks++; if (sib_open !== 1'b0) begin n_fail++; $display("FAIL tlr_sib: got %b want 0", sib_open); end
    n_checks++; if (instr_out !== 8'h00) begin n_fail++; $display("FAIL tlr_instr: got %h want 00", instr_out); end
    n_checks++; if (tdo_dr !== 1'b0) begin n_fail++; $display("FAIL tlr_tdo: got %b want 0", tdo_dr); end
    @(negedge tck);
    test_logic_reset_state = 1'b0;
    update_dr_state        = 1'b0;
    $display("test-logic-reset: outputs cleared");
  endtask

  initial begin
    ir_reg                 = 4'b0001;
    test_logic_reset_state = 1'b0;
    capture_dr_state       = 1'b0;
    shift_dr_state         = 1'b0;
    update_dr_state        = 1'b0;
    tdi                    = 1'b0;
    instr_in               = 8'h00;
    test_reset();
    test_idcode();
    test_bypass();
    test_sib_closed();
    test_sib_open();
    test_next_scan();
    test_other_dr_update();
    test_sib_close();
    test_trst_abort();
    test_tlr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/jtag_dr_unit.md
JTAG_DR_UNIT -- requirements
Module: jtag_dr_unit

Interface
REQ-001 Parameter IDCODE_VALUE, default 32'h1A2B_3C4D, device ID captured under IDCODE (bit 0 SHALL be 1).
REQ-002 Parameter TDR_WIDTH, default 8, width of the IJTAG instrument test data register (TDR).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 tck  in  1  test clock; all state updates on posedge.
REQ-005 trst_n  in  1  asynchronous active-low reset.
REQ-006 ir_reg  in  4  current instruction from the TAP controller.
REQ-007 test_logic_reset_state  in  1  TAP in Test-Logic-Reset.
REQ-008 capture_dr_state, shift_dr_state, update_dr_state  in  1 each  TAP state indicators.
REQ-009 tdi  in  1  serial data in.
REQ-010 tdo_dr  out  1  serial data out of the selected DR (to the controller TDO mux).
REQ-011 instr_in  in  TDR_WIDTH  instrument status, captured into the TDR.
REQ-012 instr_out  out  TDR_WIDTH  instrument control, the TDR update register.
REQ-013 sib_open  out  1  SIB update bit; 1 = TDR inserted in the scan path.

Function
REQ-014 DR selection SHALL be combinational from ir_reg: 4'b0001 IDCODE, 4'b0011 IJTAG_ACCESS, any other code BYPASS (EXTEST/SAMPLE included; the BSR is external).
REQ-015 Registers not selected SHALL hold their value in every TAP state.
REQ-016 Indicator priority if more than one is high: capture > shift > update; none high -> hold.
REQ-017 Capture (posedge, capture_dr_state): IDCODE shreg <= IDCODE_VALUE; bypass <= 0; SIB shift bit <= sib_open; TDR shreg <= instr_in.
REQ-018 Shift (posedge, shift_dr_state): selected chain shifts one bit toward tdo_dr, tdi enters at the far end.
REQ-019 IDCODE chain is 32 bits, LSB first; BYPASS is 1 bit.
REQ-020 IJTAG chain with sib_open=0: tdi -> SIB -> tdo_dr, length 1.
REQ-021 IJTAG chain with sib_open=1: tdi -> TDR[MSB..0] -> SIB -> tdo_dr, length TDR_WIDTH+1.
REQ-022 tdo_dr SHALL be combinational from the output-end bit of the selected chain; there is no added register (the controller retimes it).
REQ-023 Update (posedge, update_dr_state, IJTAG_ACCESS selected): sib_open <= SIB shift bit.
REQ-024 In the same update, if sib_open was 1 before the edge, instr_out <= TDR shreg; otherwise instr_out holds.
REQ-025 Opening or closing the SIB SHALL change the chain length only from the next capture onward; the current scan is unaffected.
REQ-026 Update under IDCODE or BYPASS SHALL change no output.
REQ-027 test_logic_reset_state high at posedge SHALL synchronously clear sib_open and instr_out, overriding all other activity.

Reset
REQ-028 trst_n low SHALL asynchronously clear all shift registers, bypass, sib_open (0) and instr_out (0); tdo_dr then reads 0.
REQ-029 Reset asserted mid-scan SHALL abort the scan with no partial update; operation resumes at the first capture after release.

Structure
REQ-030 Instruction codes (IDCODE, BYPASS, EXTEST, SAMPLE, IJTAG_ACCESS) and TAP state encodings SHALL live in shared package jtag_pkg.
REQ-031 The SIB (shift bit, update bit, path mux) SHALL be sub-module jtag_sib, so it is reusable in deeper 1687 networks.

Verification
REQ-032 IDCODE: capture, then 32 shifts with tdi=0 -> tdo_dr sequence equals 32'h1A2B_3C4D LSB first; after 32 shifts, 0.
REQ-033 BYPASS (ir=4'b1111): capture, then shift tdi 1,1,0,0 -> tdo_dr reads 0,1,1,0.
REQ-034 IJTAG, SIB closed: shift 1 bit tdi=1, then update -> sib_open=1 and instr_out unchanged (0).
REQ-035 IJTAG, SIB open: 9 shifts of 8'hA5 followed by SIB bit 1, then update -> instr_out=8'hA5 and sib_open=1.
REQ-036 Next scan: instr_in=8'h3C, capture, 9 shifts -> tdo_dr sequence is SIB=1 then 3C LSB first.
REQ-037 trst_n pulsed low during shift -> instr_out=0, sib_open=0, tdo_dr=0 immediately; test_logic_reset_state=1 for one posedge gives the same outputs synchronously.
